nn_layer_scheduler: RTL

Top-level sequencer for the binary NN inference engine. Runs the four fully-connected layers in order. For each layer it drives the compute datapath's bank selects (weight bank, x read bank, x write bank) and vector lengths, issues a one-cycle `layer_start`, and waits for `layer_done`. It provides a start/busy/done handshake toward the host, an abort, a per-layer watchdog and a run-cycle counter.

---
 rtl/nn_layer_scheduler.sv | 139 +++++++++++++
 1 files changed

// File: rtl/nn_layer_scheduler.sv
// nn_layer_scheduler: sequences the fully-connected layers of the binary NN
// engine. For each layer it sets the bank selects and vector lengths, fires
// a one-cycle layer_start and waits for layer_done. A host-side
// start/busy/done handshake, an abort, a per-layer watchdog and a run-cycle
// counter are also provided. All outputs are registered from the next state.
module nn_layer_scheduler #(
  parameter int NUM_LAYERS = 4,
  parameter int X_ADDR_LEN = 10,
  parameter int W_SEL_LEN  = 2,
  parameter int X_SEL_LEN  = 2,
  parameter int X1_LEN     = 2,
  parameter int X2_LEN     = 3,
  parameter int X3_LEN     = 3,
  parameter int X4_LEN     = 4,
  parameter int OUTPUT_LEN = 10,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  layer_done,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  layer_start,
  output logic [1:0]            layer_idx,
  output logic [W_SEL_LEN-1:0]  w_sel,
  output logic [X_SEL_LEN-1:0]  x_rd_sel,
  output logic [X_SEL_LEN-1:0]  x_wr_sel,
  output logic [X_ADDR_LEN-1:0] in_len,
  output logic [X_ADDR_LEN-1:0] out_len,
  output logic [31:0]           cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_CONFIG, S_FIRE, S_WAIT, S_FINISH, S_ERROR
  } state_t;

  localparam logic [1:0]  LAST_IDX = 2'(NUM_LAYERS - 1);
  // Watchdog terminal value; unused when TIMEOUT is 0.
  localparam logic [31:0] WDOG_END = 32'(TIMEOUT - 1);

  state_t                state, nxt;
  logic [1:0]            nxt_idx;
  logic [1:0]            nxt_wr;
  logic                  accept;
  logic [31:0]           wdog;
  logic [X_ADDR_LEN-1:0] nxt_in, nxt_out;

  // Next-state and next layer index; abort overrides everything but reset.
  always_comb begin
    nxt     = state;
    nxt_idx = layer_idx;
    accept  = 1'b0;
    case (state)
      S_IDLE, S_ERROR: begin
        if (start) begin
          nxt     = S_CONFIG;
          nxt_idx = 2'd0;
          accept  = 1'b1;
        end
      end
      S_CONFIG: nxt = S_FIRE;
      S_FIRE:   nxt = S_WAIT;
      S_WAIT: begin
        if (layer_done) begin
          if (layer_idx < LAST_IDX) begin
            nxt     = S_CONFIG;
            nxt_idx = layer_idx + 2'd1;
          end else begin
            nxt = S_FINISH;
          end
        end else if ((TIMEOUT != 0) && (wdog == WDOG_END)) begin
          nxt = S_ERROR;
        end
      end
      S_FINISH: nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
    if (abort && (state != S_IDLE) && (state != S_ERROR)) begin
      nxt     = S_IDLE;
      nxt_idx = 2'd0;
    end
  end

  // Per-layer vector lengths and write bank for the layer about to be configured.
  always_comb begin
    nxt_wr = nxt_idx + 2'd1;
    case (nxt_idx)
      2'd0:    begin nxt_in = X_ADDR_LEN'(X1_LEN); nxt_out = X_ADDR_LEN'(X2_LEN);     end
      2'd1:    begin nxt_in = X_ADDR_LEN'(X2_LEN); nxt_out = X_ADDR_LEN'(X3_LEN);     end
      2'd2:    begin nxt_in = X_ADDR_LEN'(X3_LEN); nxt_out = X_ADDR_LEN'(X4_LEN);     end
      default: begin nxt_in = X_ADDR_LEN'(X4_LEN); nxt_out = X_ADDR_LEN'(OUTPUT_LEN); end
    endcase
  end

  // State register plus registered outputs, watchdog and cycle counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      layer_start <= 1'b0;
      layer_idx   <= '0;
      w_sel       <= '0;
      x_rd_sel    <= '0;
      x_wr_sel    <= '0;
      in_len      <= '0;
      out_len     <= '0;
      cycle_count <= '0;
      wdog        <= '0;
    end else begin
      state       <= nxt;
      layer_idx   <= nxt_idx;
      busy        <= (nxt == S_CONFIG) || (nxt == S_FIRE) ||
                     (nxt == S_WAIT)   || (nxt == S_FINISH);
      done        <= (nxt == S_FINISH);
      layer_start <= (nxt == S_FIRE);
      // ERROR is only left through a new start, so this is sticky until then.
      error       <= (nxt == S_ERROR);
      wdog        <= ((state == S_WAIT) && (nxt == S_WAIT)) ? wdog + 32'd1 : 32'd0;
      // Config only moves on entry to CONFIG so it stays stable for the datapath.
      if (nxt == S_CONFIG) begin
        w_sel    <= W_SEL_LEN'(nxt_idx);
        x_rd_sel <= X_SEL_LEN'(nxt_idx);
        x_wr_sel <= X_SEL_LEN'(nxt_wr);
        in_len   <= nxt_in;
        out_len  <= nxt_out;
      end
      if (accept)
        cycle_count <= '0;
      else if (busy && (cycle_count != '1))
        cycle_count <= cycle_count + 32'd1;
    end
  end

endmodule
